// File: rtl/regfile_onehot_wr.sv
// RV32I integer register file, 32 x WIDTH, two async reads, one sync write.
// Write port takes a one-hot select and flags non-one-hot write attempts.
module regfile_onehot_wr #(
    parameter int                 WIDTH     = 32,
    parameter int                 BYPASS    = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [31:0]      WSEL,
    input  logic [WIDTH-1:0] WD,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             ONEHOT_ERR,
    output logic [15:0]      WR_CNT
);

    logic [WIDTH-1:0] regs [32];
    logic             onehot;
    logic             wr_ok;
    logic             wr_bad;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    always_comb begin
        onehot = (WSEL != 32'd0) && ((WSEL & (WSEL - 32'd1)) == 32'd0);
        wr_ok  = WE && onehot;
        wr_bad = WE && !onehot;
    end

    // Register storage; x0 is a constant zero and never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs[0] <= '0;
            for (int n = 1; n < 32; n++) begin
                regs[n] <= RESET_VAL;
            end
        end else begin
            for (int n = 1; n < 32; n++) begin
                if (wr_ok && WSEL[n]) begin
                    regs[n] <= WD;
                end
            end
        end
    end

    // Committed-write counter, wraps modulo 2^16 (x0 writes count too)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WR_CNT <= 16'd0;
        end else if (wr_ok) begin
            WR_CNT <= WR_CNT + 16'd1;
        end
    end

    // Sticky select-violation flag; a new violation beats a clear on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ONEHOT_ERR <= 1'b0;
        end else if (wr_bad) begin
            ONEHOT_ERR <= 1'b1;
        end else if (ERR_CLR) begin
            ONEHOT_ERR <= 1'b0;
        end
    end

    // Read port 1: stored value, optional same-cycle forward, x0 forced to zero
    always_comb begin
        RD1 = regs[RA1];
        if ((BYPASS != 0) && !reset && wr_ok && WSEL[RA1]) begin
            RD1 = WD;
        end
        if (RA1 == 5'd0) begin
            RD1 = '0;
        end
    end

    // Read port 2: same rules as port 1
    always_comb begin
        RD2 = regs[RA2];
        if ((BYPASS != 0) && !reset && wr_ok && WSEL[RA2]) begin
            RD2 = WD;
        end
        if (RA2 == 5'd0) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Randomized self-checking bench for regfile_onehot_wr.
// Runs a bypass and a non-bypass build side by side against one array model.
module tb_regfile_onehot_wr;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [31:0] WSEL;
    logic [31:0] WD;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic        ERR_CLR;

    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        err_b1, err_b0;
    logic [15:0] cnt_b1, cnt_b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [32];
    logic        m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    regfile_onehot_wr #(.WIDTH(32), .BYPASS(1), .RESET_VAL(32'd0)) dut_b1 (
        .clk(clk), .reset(reset), .WE(WE), .WSEL(WSEL), .WD(WD),
        .RA1(RA1), .RA2(RA2), .ERR_CLR(ERR_CLR),
        .RD1(rd1_b1), .RD2(rd2_b1), .ONEHOT_ERR(err_b1), .WR_CNT(cnt_b1)
    );

    regfile_onehot_wr #(.WIDTH(32), .BYPASS(0), .RESET_VAL(32'd0)) dut_b0 (
        .clk(clk), .reset(reset), .WE(WE), .WSEL(WSEL), .WD(WD),
        .RA1(RA1), .RA2(RA2), .ERR_CLR(ERR_CLR),
        .RD1(rd1_b0), .RD2(rd2_b0), .ONEHOT_ERR(err_b0), .WR_CNT(cnt_b0)
    );

    function automatic bit write_valid();
        return WE && ($countones(WSEL) == 1) && !reset;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && write_valid() && WSEL[ra]) return WD;
        return mdl[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        m_err = 1'b0;
        m_cnt = 16'd0;
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock
    task automatic tick();
        if (!reset) begin
            if (write_valid()) begin
                for (int i = 1; i < 32; i++) if (WSEL[i]) mdl[i] = WD;
                m_cnt = m_cnt + 16'd1;
            end
            if (WE && ($countones(WSEL) != 1)) m_err = 1'b1;
            else if (ERR_CLR) m_err = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        WE = 0; WSEL = 0; WD = 0; ERR_CLR = 0; RA1 = 0; RA2 = 0;
        reset = 1'b1;
        model_clear();
        #3;
        for (int a = 0; a < 32; a++) begin
            RA1 = 5'(a);
            RA2 = 5'(31 - a);
            #1;
            checks += 4;
            if (rd1_b1 !== 32'd0) begin errors++; $display("FAIL reset_rd1_b1 a=%0d got=%h exp=0", a, rd1_b1); end
            if (rd2_b1 !== 32'd0) begin errors++; $display("FAIL reset_rd2_b1 a=%0d got=%h exp=0", a, rd2_b1); end
            if (rd1_b0 !== 32'd0) begin errors++; $display("FAIL reset_rd1_b0 a=%0d got=%h exp=0", a, rd1_b0); end
            if (rd2_b0 !== 32'd0) begin errors++; $display("FAIL reset_rd2_b0 a=%0d got=%h exp=0", a, rd2_b0); end
        end
        checks += 2;
        if (err_b1 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_b1); end
        if (cnt_b1 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_b1); end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_write();
        WE = 1; WSEL = 32'h0000_0020; WD = 32'hDEAD_BEEF;
        tick();
        WE = 0; RA1 = 5'd5;
        #1;
        checks += 3;
        if (rd1_b1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_x5_b1 got=%h exp=deadbeef", rd1_b1); end
        if (rd1_b0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_x5_b0 got=%h exp=deadbeef", rd1_b0); end
        if (cnt_b1 !== 16'd1) begin errors++; $display("FAIL write_cnt got=%0d exp=1", cnt_b1); end
        WE = 1; WSEL = 32'h0000_0001; WD = 32'hFFFF_FFFF; RA1 = 5'd0;
        #1;
        checks += 1;
        if (rd1_b1 !== 32'd0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rd1_b1); end
        tick();
        WE = 0;
        #1;
        checks += 3;
        if (rd1_b1 !== 32'd0) begin errors++; $display("FAIL x0_read got=%h exp=0", rd1_b1); end
        if (cnt_b1 !== m_cnt) begin errors++; $display("FAIL x0_cnt_b1 got=%0d exp=%0d", cnt_b1, m_cnt); end
        if (cnt_b0 !== 16'd2) begin errors++; $display("FAIL x0_cnt_b0 got=%0d exp=2", cnt_b0); end
    endtask

    task automatic test_onehot_err();
        WE = 1; WSEL = 32'h0000_0002; WD = 32'h1111_1111; tick();
        WSEL = 32'h0000_0004; WD = 32'h2222_2222; tick();
        WSEL = 32'h0000_0006; WD = 32'h1234_5678; RA1 = 5'd1; RA2 = 5'd2;
        #1;
        checks += 2;
        if (rd1_b1 !== 32'h1111_1111) begin errors++; $display("FAIL bad_nobypass1 got=%h exp=11111111", rd1_b1); end
        if (rd2_b1 !== 32'h2222_2222) begin errors++; $display("FAIL bad_nobypass2 got=%h exp=22222222", rd2_b1); end
        tick();
        WE = 0;
        #1;
        checks += 4;
        if (rd1_b1 !== 32'h1111_1111) begin errors++; $display("FAIL bad_x1 got=%h exp=11111111", rd1_b1); end
        if (rd2_b0 !== 32'h2222_2222) begin errors++; $display("FAIL bad_x2 got=%h exp=22222222", rd2_b0); end
        if (err_b1 !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", err_b1); end
        if (cnt_b1 !== m_cnt) begin errors++; $display("FAIL bad_cnt got=%0d exp=%0d", cnt_b1, m_cnt); end
        ERR_CLR = 1; tick(); ERR_CLR = 0;
        checks += 1;
        if (err_b1 !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", err_b1); end
        WE = 0; WSEL = 32'h0000_00FF; tick();
        checks += 1;
        if (err_b0 !== 1'b0) begin errors++; $display("FAIL we0_noerr got=%b exp=0", err_b0); end
        WE = 1; WSEL = 32'd0; ERR_CLR = 1; tick();
        WE = 0; ERR_CLR = 0;
        checks += 2;
        if (err_b1 !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", err_b1); end
        if (cnt_b1 !== m_cnt) begin errors++; $display("FAIL zero_sel_cnt got=%0d exp=%0d", cnt_b1, m_cnt); end
        ERR_CLR = 1; tick(); ERR_CLR = 0;
    endtask

    task automatic test_bypass();
        RA1 = 5'd10; RA2 = 5'd10;
        WE = 1; WSEL = 32'h0000_0400; WD = 32'hA5A5_A5A5;
        #1;
        checks += 4;
        if (rd1_b1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_rd1 got=%h exp=a5a5a5a5", rd1_b1); end
        if (rd2_b1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_rd2 got=%h exp=a5a5a5a5", rd2_b1); end
        if (rd1_b0 !== mdl[10]) begin errors++; $display("FAIL nobyp_rd1 got=%h exp=%h", rd1_b0, mdl[10]); end
        if (rd2_b0 !== mdl[10]) begin errors++; $display("FAIL nobyp_rd2 got=%h exp=%h", rd2_b0, mdl[10]); end
        tick();
        WE = 0;
        #1;
        checks += 1;
        if (rd1_b0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL nobyp_after got=%h exp=a5a5a5a5", rd1_b0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) WSEL = 32'd1 << $urandom_range(0, 31);
            else if (r == 7) WSEL = 32'd0;
            else WSEL = $urandom;
            WE = ($urandom_range(0, 3) != 0);
            ERR_CLR = ($urandom_range(0, 7) == 0);
            WD = $urandom;
            RA1 = 5'($urandom_range(0, 31));
            RA2 = ($urandom_range(0, 3) == 0) ? RA1 : 5'($urandom_range(0, 31));
            #1;
            checks += 6;
            if (rd1_b1 !== exp_rd(RA1, 1)) begin errors++; $display("FAIL rnd_rd1_b1 c=%0d ra=%0d got=%h exp=%h", c, RA1, rd1_b1, exp_rd(RA1, 1)); end
            if (rd2_b1 !== exp_rd(RA2, 1)) begin errors++; $display("FAIL rnd_rd2_b1 c=%0d ra=%0d got=%h exp=%h", c, RA2, rd2_b1, exp_rd(RA2, 1)); end
            if (rd1_b0 !== exp_rd(RA1, 0)) begin errors++; $display("FAIL rnd_rd1_b0 c=%0d ra=%0d got=%h exp=%h", c, RA1, rd1_b0, exp_rd(RA1, 0)); end
            if (rd2_b0 !== exp_rd(RA2, 0)) begin errors++; $display("FAIL rnd_rd2_b0 c=%0d ra=%0d got=%h exp=%h", c, RA2, rd2_b0, exp_rd(RA2, 0)); end
            if (err_b1 !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_b1, m_err); end
            if (cnt_b0 !== m_cnt) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, cnt_b0, m_cnt); end
            tick();
        end
        WE = 0; ERR_CLR = 0;
    endtask

    task automatic test_async_reset();
        WE = 1; WSEL = 32'h0000_0080; WD = 32'h0000_0001;
        tick();
        WE = 0; RA1 = 5'd7;
        #1;
        checks += 1;
        if (rd1_b1 !== 32'd1) begin errors++; $display("FAIL ar_pre got=%h exp=1", rd1_b1); end
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        checks += 3;
        if (rd1_b1 !== 32'd0) begin errors++; $display("FAIL ar_x7_b1 got=%h exp=0", rd1_b1); end
        if (rd1_b0 !== 32'd0) begin errors++; $display("FAIL ar_x7_b0 got=%h exp=0", rd1_b0); end
        if (cnt_b1 !== 16'd0) begin errors++; $display("FAIL ar_cnt got=%0d exp=0", cnt_b1); end
        WE = 1; WSEL = 32'h0000_0080; WD = 32'h5555_5555;
        #1;
        checks += 1;
        if (rd1_b1 !== 32'd0) begin errors++; $display("FAIL ar_bypass got=%h exp=0", rd1_b1); end
        tick();
        checks += 2;
        if (rd1_b0 !== 32'd0) begin errors++; $display("FAIL ar_pending got=%h exp=0", rd1_b0); end
        if (cnt_b0 !== 16'd0) begin errors++; $display("FAIL ar_pend_cnt got=%0d exp=0", cnt_b0); end
        WE = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        WE = 1;
        for (int i = 0; i < 65535; i++) begin
            WSEL = 32'd1 << (i % 32);
            WD = 32'(i);
            tick();
        end
        checks += 1;
        if (cnt_b1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ffff", cnt_b1); end
        WSEL = 32'h0000_8000; WD = 32'hCAFE_F00D;
        tick();
        WE = 0; RA1 = 5'd15; RA2 = 5'd14;
        #1;
        checks += 4;
        if (cnt_b1 !== 16'd0) begin errors++; $display("FAIL wrap_b1 got=%h exp=0", cnt_b1); end
        if (cnt_b0 !== m_cnt) begin errors++; $display("FAIL wrap_b0 got=%h exp=%h", cnt_b0, m_cnt); end
        if (rd1_b1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_x15 got=%h exp=cafef00d", rd1_b1); end
        if (rd2_b0 !== mdl[14]) begin errors++; $display("FAIL wrap_x14 got=%h exp=%h", rd2_b0, mdl[14]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_onehot_err();
        test_bypass();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
